// File: rtl/rr_arb4.sv
// rr_arb4: four-way round-robin arbiter with registered one-hot grant,
// hold timeout and a mandatory idle turnaround between grants.
module rr_arb4 #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       busy,
  output logic       to_evt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] idx_n;
  logic [7:0] hold, hold_n;
  logic [1:0] ptr, ptr_n;
  logic       to_n;
  logic [1:0] win;
  logic       win_ok;
  logic       hit_to;
  logic       rel_user;

  // scan from ptr+4 (== ptr) down to ptr+1 so the nearest match wins last
  always_comb begin
    win    = ptr;
    win_ok = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (req[ptr + 2'(k)]) begin
        win    = ptr + 2'(k);
        win_ok = 1'b1;
      end
    end
  end

  assign hit_to   = (hold == HOLD_LAST);
  assign rel_user = done || !req[gnt_idx];

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    hold_n  = hold;
    ptr_n   = ptr;
    to_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_ok) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          idx_n   = win;
          hold_n  = 8'd0;
          ptr_n   = win;
        end
      end
      GRANT: begin
        if (hit_to || rel_user) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          idx_n   = 2'b00;
          hold_n  = 8'd0;
          to_n    = hit_to && !rel_user;
        end else if (hold != 8'hFF) begin
          hold_n = hold + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        idx_n   = 2'b00;
        hold_n  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 4'b0000;
      gnt_idx <= 2'b00;
      hold    <= 8'd0;
      ptr     <= 2'b11;
      to_evt  <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      hold    <= hold_n;
      ptr     <= ptr_n;
      to_evt  <= to_n;
    end
  end

  assign busy = |gnt;

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles one grant is held; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester request; bit i = requester i.
REQ-005 done  input  1  current owner releases the shared resource this cycle.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 gnt_idx  output  2  binary index of owner (encoded form of gnt); 2'b00 when gnt is zero.
REQ-008 busy  output  1  high exactly when gnt is non-zero.
REQ-009 to_evt  output  1  one-cycle pulse: current grant ended by timeout.

Function
REQ-010 FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-011 In IDLE with req==0, the FSM SHALL stay in IDLE with gnt=0, busy=0, to_evt=0.
REQ-012 In IDLE with req!=0 at edge N, the block SHALL drive gnt/gnt_idx/busy for the winner from edge N+1 (1-cycle grant latency), enter GRANT, and clear the hold counter to 0.
REQ-013 Winner selection SHALL be round-robin: scan indices ptr+1, ptr+2, ptr+3, ptr (mod 4); first set req bit wins.
REQ-014 ptr (2-bit) SHALL load the winner index on every grant; ptr is not updated in any other state or cycle.
REQ-015 gnt SHALL always be zero or one-hot; gnt_idx SHALL always equal the encoded index of gnt.
REQ-016 In GRANT, the hold counter SHALL increment by 1 each cycle, saturating at 255.
REQ-017 In GRANT, the grant SHALL release at the next edge if any holds: done==1; req[gnt_idx]==0; hold counter == TIMEOUT-1.
REQ-018 On release, the FSM SHALL return to IDLE: gnt=0, busy=0 for at least one cycle (mandatory 1-cycle turnaround) before any new grant.
REQ-019 to_evt SHALL pulse high for the single cycle following a release caused only by timeout; if done==1 or req drop coincides with the timeout, to_evt SHALL stay 0.
REQ-020 Requests from non-owners during GRANT SHALL NOT affect gnt; they are arbitrated in the IDLE cycle after release.
REQ-021 With TIMEOUT=1, each grant SHALL last exactly 1 cycle.
REQ-022 Continuously asserted requesters SHALL each be granted within 4 grants (starvation-free).

Reset
REQ-023 While rst is high at a clock edge, the block SHALL set state=IDLE, gnt=4'b0000, gnt_idx=2'b00, busy=0, to_evt=0, hold counter=0, ptr=2'b11 (so index 0 has first priority).
REQ-024 rst asserted during GRANT SHALL drop the grant at that edge with no to_evt pulse; rst overrides all other inputs.
REQ-025 The first cycle after rst deasserts SHALL behave as IDLE.

Verification
REQ-026 After rst, req=4'b1111 held, done pulsed 1 cycle per grant -> gnt sequence 0001,0010,0100,1000,0001 with gnt_idx 0,1,2,3,0 and one zero-gnt cycle between grants.
REQ-027 req=4'b0100 at edge N after reset -> gnt=0100, gnt_idx=2'b10, busy=1 from edge N+1; req[2] dropped -> gnt=0 at next edge.
REQ-028 TIMEOUT=8, req=4'b0001 held, done=0 -> gnt=0001 for exactly 8 cycles, then to_evt=1 for 1 cycle with gnt=0, then regranted to 0001.
REQ-029 During a grant to 0, req goes to 4'b1011 -> gnt stays 0001 until release, next grant 0010, then 1000, then 0001.
REQ-030 rst asserted mid-grant (gnt=1000) -> next edge gnt=0000, busy=0, to_evt=0; with req=4'b1001 after release, first grant is 0001.
REQ-031 Every cycle, checker asserts: gnt zero or one-hot, busy==|gnt, gnt_idx==encode(gnt), to_evt implies gnt==0.
